// File: rtl/frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx
// Brief    : Byte-serial frame source (2-byte header + payload) for aligner
//            bring-up, with header-corruption injection.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tx #(
  parameter logic [7:0] HDR1_MSB    = 8'hAA,
  parameter logic [7:0] HDR1_LSB    = 8'hAF,
  parameter logic [7:0] HDR2_MSB    = 8'hBA,
  parameter logic [7:0] HDR2_LSB    = 8'hBC,
  parameter int         PAYLOAD_LEN = 10,
  parameter logic [7:0] IDLE_BYTE   = 8'h00,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hdr_sel,
  input  logic        corrupt_hdr,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic        underrun_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic [3:0]  tx_byte_position,
  output logic        frame_done,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0] c_LAST_POS = 4'(PAYLOAD_LEN + 1);
  localparam logic [3:0] c_IDLE_POS = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR_MSB = 2'd1,
    ST_HDR_LSB = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  state_t r_state;
  logic   r_sel;
  logic   r_corrupt;

  logic       w_last;
  logic       w_start;
  logic [3:0] w_pos_next;
  logic [7:0] w_hdr_lsb;

  assign w_last     = (r_state == ST_PAYLOAD) && (tx_byte_position == c_LAST_POS);
  assign w_start    = ((r_state == ST_IDLE) || w_last) && enable;
  assign w_pos_next = tx_byte_position + 4'd1;
  assign w_hdr_lsb  = (r_sel ? HDR2_LSB : HDR1_LSB) ^ {7'b0, r_corrupt};

  // Idle position 4'hF lies above L-1, so the range test alone is sufficient.
  assign pl_ready = (tx_byte_position >= 4'd1) &&
                    (tx_byte_position <= (c_LAST_POS - 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_sel            <= 1'b0;
      r_corrupt        <= 1'b0;
      tx_data          <= IDLE_BYTE;
      tx_valid         <= 1'b0;
      tx_byte_position <= c_IDLE_POS;
      frame_done       <= 1'b0;
      underrun         <= 1'b0;
      frame_cnt        <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      // A fill event later in this block overrides the clear.
      if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (w_start) begin
        r_state          <= ST_HDR_MSB;
        r_sel            <= hdr_sel;
        r_corrupt        <= corrupt_hdr;
        tx_data          <= hdr_sel ? HDR2_MSB : HDR1_MSB;
        tx_valid         <= 1'b1;
        tx_byte_position <= 4'd0;
      end else if (w_last) begin
        r_state          <= ST_IDLE;
        tx_data          <= IDLE_BYTE;
        tx_valid         <= 1'b0;
        tx_byte_position <= c_IDLE_POS;
      end else begin
        case (r_state)
          ST_HDR_MSB: begin
            r_state          <= ST_HDR_LSB;
            tx_data          <= w_hdr_lsb;
            tx_valid         <= 1'b1;
            tx_byte_position <= 4'd1;
          end
          ST_HDR_LSB, ST_PAYLOAD: begin
            r_state          <= ST_PAYLOAD;
            tx_valid         <= 1'b1;
            tx_byte_position <= w_pos_next;
            if (pl_valid) begin
              tx_data <= pl_data;
            end else begin
              tx_data  <= FILL_BYTE;
              underrun <= 1'b1;
            end
            if (w_pos_next == c_LAST_POS) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end
          end
          default: begin
            r_state          <= ST_IDLE;
            tx_data          <= IDLE_BYTE;
            tx_valid         <= 1'b0;
            tx_byte_position <= c_IDLE_POS;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_tx
// Brief    : Vector/scoreboard bench for frame_tx with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        hdr_sel;
  logic        corrupt_hdr;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        underrun_clr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [3:0]  tx_byte_position;
  logic        frame_done;
  logic        underrun;
  logic [15:0] frame_cnt;

  frame_tx u_dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .hdr_sel          (hdr_sel),
    .corrupt_hdr      (corrupt_hdr),
    .pl_data          (pl_data),
    .pl_valid         (pl_valid),
    .pl_ready         (pl_ready),
    .underrun_clr     (underrun_clr),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_byte_position (tx_byte_position),
    .frame_done       (frame_done),
    .underrun         (underrun),
    .frame_cnt        (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, sel, cor, pv, clr;
    logic [7:0]  pd;
    logic        e_rdy;
    logic [7:0]  e_data;
    logic        e_valid;
    logic [3:0]  e_pos;
    logic        e_done;
    logic        e_under;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t        vec[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_idx = -1;
  logic [15:0] g_cnt = 16'd0;
  logic        g_under = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d, t=%0t): got %h, expected %h", nm, cur_idx, $time, act, exp);
    end
  endtask

  task automatic add(input logic en, sel, cor, input logic [7:0] pd, input logic pv, clr,
                     input logic rdy, input logic [7:0] d, input logic v,
                     input logic [3:0] p, input logic dn);
    vec_t r;
    r.en = en; r.sel = sel; r.cor = cor; r.pd = pd; r.pv = pv; r.clr = clr;
    r.e_rdy = rdy; r.e_data = d; r.e_valid = v; r.e_pos = p; r.e_done = dn;
    r.e_under = g_under; r.e_cnt = g_cnt;
    vec.push_back(r);
  endtask

  task automatic gen_idle(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      if (clr) g_under = 1'b0;
      add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, clr, 1'b0, 8'h00, 1'b0, 4'hF, 1'b0);
    end
  endtask

  // Header selects are flipped after frame start to prove they are latched.
  task automatic gen_frame(input logic sel, cor, input logic [7:0] base,
                           input int drop, input logic clr_drop, input logic mid_en);
    logic [7:0] lsb;
    lsb = (sel ? 8'hBC : 8'hAF) ^ {7'b0, cor};
    add(1'b1, sel, cor, 8'hEE, 1'b1, 1'b0, 1'b0, sel ? 8'hBA : 8'hAA, 1'b1, 4'd0, 1'b0);
    add(mid_en, !sel, !cor, 8'hEE, 1'b1, 1'b0, 1'b0, lsb, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      int         p;
      logic       pv, c;
      logic [7:0] d;
      p  = i + 2;
      pv = (p != drop);
      c  = (p == drop) && clr_drop;
      d  = 8'(base + 8'(i));
      if (!pv) g_under = 1'b1;
      else if (c) g_under = 1'b0;
      if (p == 11) g_cnt = g_cnt + 16'd1;
      add(mid_en, !sel, !cor, d, pv, c, 1'b1, pv ? d : 8'h00, 1'b1, 4'(p), p == 11);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_data",  {8'h0, tx_data}, 16'h0000);
    chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("rst_pos",      {12'h0, tx_byte_position}, 16'h000F);
    chk("rst_done",     {15'h0, frame_done}, 16'h0000);
    chk("rst_underrun", {15'h0, underrun}, 16'h0000);
    chk("rst_cnt",      frame_cnt, 16'h0000);
    chk("rst_ready",    {15'h0, pl_ready}, 16'h0000);
  endtask

  initial begin
    vec_t v;
    int   n;
    reset = 1'b0; enable = 1'b0; hdr_sel = 1'b0; corrupt_hdr = 1'b0;
    pl_data = 8'h00; pl_valid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;

    gen_idle(20, 1'b0);
    gen_frame(1'b0, 1'b0, 8'h01, 0, 1'b0, 1'b0);          // single type-1 frame
    gen_idle(3, 1'b0);
    gen_frame(1'b0, 1'b0, 8'h11, 0, 1'b0, 1'b1);          // three contiguous frames
    gen_frame(1'b1, 1'b0, 8'h21, 0, 1'b0, 1'b1);
    gen_frame(1'b1, 1'b0, 8'h31, 0, 1'b0, 1'b0);
    gen_idle(2, 1'b0);
    gen_frame(1'b0, 1'b0, 8'h41, 5, 1'b0, 1'b0);          // fill at position 5
    gen_idle(2, 1'b0);
    gen_idle(2, 1'b1);
    gen_frame(1'b0, 1'b0, 8'h51, 7, 1'b1, 1'b0);          // fill and clear together
    gen_idle(1, 1'b0);
    gen_idle(1, 1'b1);
    gen_frame(1'b1, 1'b1, 8'h61, 0, 1'b0, 1'b1);          // corrupted type-2 header
    gen_frame(1'b1, 1'b0, 8'h71, 0, 1'b0, 1'b0);
    gen_idle(3, 1'b0);

    n = vec.size();
    for (int i = 0; i < n; i++) begin
      cur_idx = i;
      v = vec.pop_front();
      enable = v.en; hdr_sel = v.sel; corrupt_hdr = v.cor;
      pl_data = v.pd; pl_valid = v.pv; underrun_clr = v.clr;
      #1;
      chk("pl_ready", {15'h0, pl_ready}, {15'h0, v.e_rdy});
      @(posedge clk);
      #1;
      chk("tx_data",    {8'h0, tx_data}, {8'h0, v.e_data});
      chk("tx_valid",   {15'h0, tx_valid}, {15'h0, v.e_valid});
      chk("tx_pos",     {12'h0, tx_byte_position}, {12'h0, v.e_pos});
      chk("frame_done", {15'h0, frame_done}, {15'h0, v.e_done});
      chk("underrun",   {15'h0, underrun}, {15'h0, v.e_under});
      chk("frame_cnt",  frame_cnt, v.e_cnt);
    end

    // Reset mid-frame at position 6, then a clean restart.
    cur_idx = -2;
    enable = 1'b0; underrun_clr = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b1; hdr_sel = 1'b0; corrupt_hdr = 1'b0;
    pl_valid = 1'b1; pl_data = 8'h55;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_pos", {12'h0, tx_byte_position}, 16'h0006);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    chk("held_rst_pos", {12'h0, tx_byte_position}, 16'h000F);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_pos0",  {12'h0, tx_byte_position}, 16'h0000);
    chk("restart_msb",   {8'h0, tx_data}, 16'h00AA);
    chk("restart_valid", {15'h0, tx_valid}, 16'h0001);
    @(posedge clk);
    #1;
    chk("restart_pos1", {12'h0, tx_byte_position}, 16'h0001);
    chk("restart_lsb",  {8'h0, tx_data}, 16'h00AF);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("restart_pos11", {12'h0, tx_byte_position}, 16'h000B);
    chk("restart_data",  {8'h0, tx_data}, 16'h0055);
    chk("restart_done",  {15'h0, frame_done}, 16'h0001);
    chk("restart_cnt",   frame_cnt, 16'h0001);
    @(posedge clk);
    #1;
    chk("restart_idle", {12'h0, tx_byte_position}, 16'h000F);
    chk("restart_done_low", {15'h0, frame_done}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
